param_universal_shreg: RTL
==========================

// Module: param_universal_shreg
// PURPOSE
//  Parametrised universal shift register; next generation of the 4-bit universal shift register.
//  Width is configurable and each operation shifts by 0..WIDTH-1 bit positions in one cycle.
//  Eight ops: hold, logical shift L/R with serial fill, load, rotate L/R, arithmetic shift R, clear.
//  Serial outputs allow chaining; an optional status bit records the carry bit shifted out.
// PARAMETERS
//  WIDTH    8     register width; power of two, >= 2
//  RST_VAL  0     dout value loaded on reset (WIDTH bits)
//  AMT_W    localparam = $clog2(WIDTH); width of the shift-amount port
// PORTS
//  clk     in   1        rising-edge clock
//  rst     in   1        synchronous reset, active high
//  en      in   1        operation enable; 0 = hold
//  mode    in   3        operation select (see BEHAVIOUR)
//  amt     in   AMT_W    shift/rotate distance, 0..WIDTH-1
//  din     in   WIDTH    parallel load data
//  sin_r   in   1        fill bit entering the MSB side on logical shift right
//  sin_l   in   1        fill bit entering the LSB side on shift left
//  dout    out  WIDTH    register contents
//  sout_r  out  1        dout[0], combinational, for chaining right
//  sout_l  out  1        dout[WIDTH-1], combinational, for chaining left
//  cout    out  1        last bit shifted out; present only with USR_STATUS_EN
// BEHAVIOUR
//  - One clock, synchronous active-high reset; everything updates on the clk rising edge.
//  - rst=1 has priority over en/mode: dout<=RST_VAL, cout<=0.
//  - en=0: dout and cout hold. Latency is 1 cycle from inputs to dout.
//  - Modes with en=1 (Q = current dout, n = amt):
//      000 hold           Q unchanged
//      001 shr logical    Q>>n; the top n bits are filled with sin_r
//      010 shl            Q<<n; the low n bits are filled with sin_l
//      011 load           Q<=din (amt ignored)
//      100 rotate right   {Q[n-1:0], Q[WIDTH-1:n]}
//      101 rotate left    {Q[WIDTH-1-n:0], Q[WIDTH-1:WIDTH-n]}
//      110 shr arithmetic Q>>>n; fill is Q[WIDTH-1]
//      111 clear          Q<=0
//  - n=0 in modes 001/010/100/101/110: dout is unchanged and cout holds (not a 1-bit shift).
//  - amt is always < WIDTH because WIDTH is a power of two; no clamping logic is needed.
//  - sout_r and sout_l reflect the registered dout in the same cycle; no added latency.
//  - There is no X-propagation on undefined modes; all 8 codes are defined.
// CONFIGURATION
//  USR_STATUS_EN defined:
//   - cout is present and registered. For n>0 it updates to:
//       001/110 -> Q[n-1]
//       010     -> Q[WIDTH-n]
//       100     -> Q[n-1]
//       101     -> Q[WIDTH-n]
//   - Modes 000/011/111 and n=0 hold cout.
//  USR_STATUS_EN undefined: cout port and its register are absent; dout behaviour is identical.
// TESTING  (WIDTH=8, RST_VAL=0)
//  1. rst=1 for 2 clk -> dout=8'h00, cout=0; then en=1, mode=011, din=8'hA5 -> dout=8'hA5 after 1 edge
//  2. Q=8'hA5, mode=001, amt=3, sin_r=1 -> dout=8'hF4, cout=1; then mode=000 -> holds 8'hF4
//  3. Q=8'h81, mode=010, amt=1, sin_l=0 -> dout=8'h02, cout=1; Q=8'hA5, mode=101, amt=4 -> dout=8'h5A
//  4. Q=8'h90, mode=110, amt=2 -> dout=8'hE4; Q=8'h01, mode=100, amt=1 -> dout=8'h80, cout=1, sout_l=1
//  5. en=0, mode=011, din=8'hFF -> dout unchanged; mode=001, amt=0 -> unchanged, cout held; mode=111 -> 8'h00
//  6. Mid-stream rst=1 together with en=1, mode=011, din=8'h3C -> dout=8'h00 (reset wins); repeat build without USR_STATUS_EN

Source files
------------

// File: rtl/param_universal_shreg_if.sv
// Control/data bundle for param_universal_shreg; the cout status line exists only
// when the design is built with USR_STATUS_EN defined.
interface param_universal_shreg_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             en;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] dout;
    logic             sout_r;
    logic             sout_l;
`ifdef USR_STATUS_EN
    logic             cout;
`endif

    modport master (
        output en, mode, amt, din, sin_r, sin_l,
`ifdef USR_STATUS_EN
        input  cout,
`endif
        input  dout, sout_r, sout_l
    );

    modport slave (
        input  en, mode, amt, din, sin_r, sin_l,
`ifdef USR_STATUS_EN
        output cout,
`endif
        output dout, sout_r, sout_l
    );
endinterface

// File: rtl/param_universal_shreg.sv
// Parametrised universal shift register: barrel shift/rotate by 0..WIDTH-1 per cycle.
// Optional carry-out status register enabled by defining USR_STATUS_EN.
module param_universal_shreg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic                    clk,
    input logic                    rst,
    param_universal_shreg_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_LOAD = 3'b011,
        M_ROR  = 3'b100,
        M_ROL  = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_e;

    function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] q,
                                                  input logic [AMT_W-1:0] n,
                                                  input logic             fill);
        logic [WIDTH-1:0] mask;
        mask = ~({WIDTH{1'b1}} >> n);
        return (q >> n) | (fill ? mask : '0);
    endfunction

    function automatic logic [WIDTH-1:0] shl_fill(input logic [WIDTH-1:0] q,
                                                  input logic [AMT_W-1:0] n,
                                                  input logic             fill);
        logic [WIDTH-1:0] mask;
        mask = ~({WIDTH{1'b1}} << n);
        return (q << n) | (fill ? mask : '0);
    endfunction

    function automatic logic [WIDTH-1:0] shr_arith(input logic [WIDTH-1:0] q,
                                                   input logic [AMT_W-1:0] n);
        logic signed [WIDTH-1:0] sq;
        logic signed [WIDTH-1:0] r;
        sq = signed'(q);
        r  = sq >>> n;
        return unsigned'(r);
    endfunction

    // Rotations use a doubled copy so the wrapped bits fall into the kept half.
    function automatic logic [WIDTH-1:0] rot_r(input logic [WIDTH-1:0] q,
                                               input logic [AMT_W-1:0] n);
        logic [2*WIDTH-1:0] d;
        d = {q, q} >> n;
        return d[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] rot_l(input logic [WIDTH-1:0] q,
                                               input logic [AMT_W-1:0] n);
        logic [2*WIDTH-1:0] d;
        d = {q, q} << n;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        q_next = q;
        case (mode)
            M_HOLD:  q_next = q;
            M_SHR:   q_next = shr_fill(q, bus.amt, bus.sin_r);
            M_SHL:   q_next = shl_fill(q, bus.amt, bus.sin_l);
            M_LOAD:  q_next = bus.din;
            M_ROR:   q_next = rot_r(q, bus.amt);
            M_ROL:   q_next = rot_l(q, bus.amt);
            M_ASR:   q_next = shr_arith(q, bus.amt);
            M_CLR:   q_next = '0;
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (bus.en) begin
            q <= q_next;
        end
    end

    assign bus.dout   = q;
    assign bus.sout_r = q[0];
    assign bus.sout_l = q[WIDTH-1];

`ifdef USR_STATUS_EN
    logic             c;
    logic             c_next;
    logic [AMT_W-1:0] idx_lo;
    logic [AMT_W-1:0] idx_hi;

    // Modulo-WIDTH arithmetic: idx_hi equals WIDTH-amt for every non-zero amt.
    assign idx_lo = bus.amt - AMT_W'(1);
    assign idx_hi = AMT_W'(0) - bus.amt;

    always_comb begin
        c_next = c;
        if (bus.amt != '0) begin
            case (mode)
                M_SHR, M_ASR, M_ROR: c_next = q[idx_lo];
                M_SHL, M_ROL:        c_next = q[idx_hi];
                default:             c_next = c;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 1'b0;
        end else if (bus.en) begin
            c <= c_next;
        end
    end

    assign bus.cout = c;
`endif
endmodule
